// File: rtl/apb_cmd_bridge.sv
// apb_cmd_bridge
//   Queues read/write commands from a valid/ready interface and plays them
//   onto APB as SETUP/ACCESS transfers, honouring PREADY wait states.
//   Read data and PSLVERR return through a response FIFO in issue order.
//
// Ports
//   pclk, prst          clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready     command handshake; ready = command FIFO not full
//   cmd_write/addr/wdata command payload (wdata ignored for reads)
//   rsp_valid/ready     response handshake; valid = response FIFO not empty
//   rsp_rdata/rsp_err   read data and PSLVERR at the response FIFO head
//   psel/penable/pwrite/paddr/pwdata  APB master outputs
//   prdata/pready/pslverr             APB slave returns
//   busy                transfer in progress or commands still queued
module apb_cmd_bridge #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW:0] DEPTH_L = DEPTH[PW:0];

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state_q, state_d;

  // Command FIFO
  logic              cmd_w_mem [DEPTH];
  logic [ADDR_W-1:0] cmd_a_mem [DEPTH];
  logic [DATA_W-1:0] cmd_d_mem [DEPTH];
  logic [PW-1:0]     cwp_q, cwp_d, crp_q, crp_d;
  logic              cfull_q, cfull_d;
  logic              cmd_empty, cmd_push;

  // Response FIFO
  logic [DATA_W-1:0] rsp_d_q [DEPTH];
  logic              rsp_e_q [DEPTH];
  logic [PW-1:0]     rwp_q, rwp_d, rrp_q, rrp_d;
  logic [PW-1:0]     rsp_cnt;
  logic [PW:0]       rsp_occ;
  logic              rsp_empty, rsp_push, rsp_pop;

  // APB output registers
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;

  // Head-of-queue view and FSM controls
  logic              head_vld, head_w;
  logic [ADDR_W-1:0] head_a;
  logic [DATA_W-1:0] head_d;
  logic              can_issue, issue;

  assign cmd_empty = (cwp_q == crp_q);
  assign cmd_push  = cmd_valid & ~cfull_q;
  assign cmd_ready = ~cfull_q;

  // An empty FIFO presents the incoming command as its head so a command
  // accepted while idle reaches SETUP on the very edge it is pushed; the
  // entry is written and consumed together, leaving the pointers equal.
  assign head_vld = ~cmd_empty | cmd_push;
  assign head_w   = cmd_empty ? cmd_write : cmd_w_mem[crp_q[AW-1:0]];
  assign head_a   = cmd_empty ? cmd_addr  : cmd_a_mem[crp_q[AW-1:0]];
  assign head_d   = cmd_empty ? cmd_wdata : cmd_d_mem[crp_q[AW-1:0]];

  assign rsp_empty = (rwp_q == rrp_q);
  assign rsp_pop   = rsp_ready & ~rsp_empty;
  assign rsp_cnt   = rwp_q - rrp_q;
  // Occupancy including a read completing this cycle, so the slot a newly
  // issued read will need is already guaranteed.
  assign rsp_occ   = {1'b0, rsp_cnt} + {{PW{1'b0}}, rsp_push};

  always_comb begin
    state_d   = state_q;
    can_issue = 1'b0;
    rsp_push  = 1'b0;
    issue     = 1'b0;
    unique case (state_q)
      IDLE:   can_issue = 1'b1;
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          rsp_push  = ~pwrite_q;
          can_issue = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (can_issue && head_vld && (head_w || (rsp_occ < DEPTH_L))) begin
      issue   = 1'b1;
      state_d = SETUP;
    end
  end

  assign cwp_d   = cwp_q + PW'(cmd_push);
  assign crp_d   = crp_q + PW'(issue);
  assign cfull_d = (cwp_d[AW] != crp_d[AW]) && (cwp_d[AW-1:0] == crp_d[AW-1:0]);
  assign rwp_d   = rwp_q + PW'(rsp_push);
  assign rrp_d   = rrp_q + PW'(rsp_pop);

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q  <= IDLE;
      cwp_q    <= '0;
      crp_q    <= '0;
      cfull_q  <= 1'b0;
      rwp_q    <= '0;
      rrp_q    <= '0;
      pwrite_q <= 1'b0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else begin
      state_q <= state_d;
      cwp_q   <= cwp_d;
      crp_q   <= crp_d;
      cfull_q <= cfull_d;
      rwp_q   <= rwp_d;
      rrp_q   <= rrp_d;
      if (issue) begin
        pwrite_q <= head_w;
        paddr_q  <= head_a;
        pwdata_q <= head_d;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (cmd_push) begin
      cmd_w_mem[cwp_q[AW-1:0]] <= cmd_write;
      cmd_a_mem[cwp_q[AW-1:0]] <= cmd_addr;
      cmd_d_mem[cwp_q[AW-1:0]] <= cmd_wdata;
    end
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rsp_d_q[i] <= '0;
        rsp_e_q[i] <= 1'b0;
      end
    end else if (rsp_push) begin
      rsp_d_q[rwp_q[AW-1:0]] <= prdata;
      rsp_e_q[rwp_q[AW-1:0]] <= pslverr;
    end
  end

  assign rsp_valid = ~rsp_empty;
  assign rsp_rdata = rsp_d_q[rrp_q[AW-1:0]];
  assign rsp_err   = rsp_e_q[rrp_q[AW-1:0]];

  assign psel    = (state_q != IDLE);
  assign penable = (state_q == ACCESS);
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign busy    = (state_q != IDLE) | ~cmd_empty;

endmodule

// File: tb/tb_apb_cmd_bridge.sv
// Bench for apb_cmd_bridge: directed scenarios, a queue-based transaction
// model checked every cycle, and hand-computed literal expectations.
module tb_apb_cmd_bridge;

  localparam int DEPTH = 4;

  logic        pclk = 1'b0;
  logic        prst;
  logic        cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        cmd_ready, rsp_valid, rsp_err;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        psel, penable, pwrite, busy;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready = 1'b1, pslverr = 1'b0;
  logic        use_fn = 1'b0;
  logic [31:0] prdata_v = '0;
  logic        chk_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] fn(input logic [31:0] a);
    return a ^ 32'hCAFE_0000;
  endfunction

  assign prdata = use_fn ? fn(paddr) : prdata_v;

  always #5 pclk = ~pclk;

  apb_cmd_bridge #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
    .pclk(pclk), .prst(prst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy(busy)
  );

  // ---------------- transaction model ----------------
  typedef struct { bit w; logic [31:0] a; logic [31:0] d; } cmd_t;
  typedef struct { logic [31:0] d; bit e; } rsp_t;

  cmd_t cmdq[$];
  rsp_t rspq[$];
  int          m_phase = 0;   // 0 no transfer, 1 first APB cycle, 2 enable cycle
  bit          m_w = 1'b0;
  logic [31:0] m_a = '0, m_d = '0;

  task automatic model_step();
    bit push_ok, rsp_pop, can_issue, have_new;
    int occ;
    rsp_t nr;
    cmd_t c;
    if (!prst) begin
      cmdq.delete(); rspq.delete();
      m_phase = 0; m_w = 1'b0; m_a = '0; m_d = '0;
      return;
    end
    push_ok   = cmd_valid && (cmdq.size() < DEPTH);
    rsp_pop   = rsp_ready && (rspq.size() != 0);
    occ       = rspq.size();
    can_issue = 1'b0;
    have_new  = 1'b0;
    case (m_phase)
      1: m_phase = 2;
      2: if (pready) begin
           if (!m_w) begin
             nr.d = use_fn ? fn(m_a) : prdata_v;
             nr.e = pslverr;
             have_new = 1'b1;
             occ++;
           end
           can_issue = 1'b1;
         end
      default: can_issue = 1'b1;
    endcase
    if (push_ok) begin
      c.w = cmd_write; c.a = cmd_addr; c.d = cmd_wdata;
      cmdq.push_back(c);
    end
    if (rsp_pop) void'(rspq.pop_front());
    if (have_new) rspq.push_back(nr);
    if (can_issue) begin
      if (cmdq.size() != 0 && (cmdq[0].w || occ < DEPTH)) begin
        c = cmdq.pop_front();
        m_w = c.w; m_a = c.a; m_d = c.d;
        m_phase = 1;
      end else begin
        m_phase = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge pclk or negedge prst);
    model_step();
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge pclk);
    if (prst && chk_en) begin
      chk("m_psel",      psel,      m_phase != 0);
      chk("m_penable",   penable,   m_phase == 2);
      chk("m_pwrite",    pwrite,    m_w);
      chk("m_paddr",     paddr,     m_a);
      chk("m_pwdata",    pwdata,    m_d);
      chk("m_busy",      busy,      (m_phase != 0) || (cmdq.size() != 0));
      chk("m_cmd_ready", cmd_ready, cmdq.size() < DEPTH);
      chk("m_rsp_valid", rsp_valid, rspq.size() != 0);
      if (rspq.size() != 0) begin
        chk("m_rsp_rdata", rsp_rdata, rspq[0].d);
        chk("m_rsp_err",   rsp_err,   rspq[0].e);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge pclk);
  endtask

  task automatic push(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 200) begin
      @(negedge pclk);
      n++;
    end
    chk("push_accept", cmd_ready, 1'b1);
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || psel) && n < 300) begin
      @(negedge pclk);
      n++;
    end
    chk("idle_reached", busy | psel, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prst = 1'b0;
    repeat (3) tick();
    chk("rst_psel", psel, 0);       chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);   chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", paddr, 0);     chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0); chk("rst_rsp_err", rsp_err, 0);
    prst = 1'b1;
    tick();
    chk("rel_cmd_ready", cmd_ready, 1);
    chk_en = 1'b1;

    // Single zero-wait write
    pready = 1'b1;
    push(1'b1, 32'h10, 32'hDEADBEEF);
    chk("w1_setup_psel", psel, 1);  chk("w1_setup_pen", penable, 0);
    chk("w1_paddr", paddr, 32'h10); chk("w1_pwdata", pwdata, 32'hDEADBEEF);
    chk("w1_pwrite", pwrite, 1);
    tick();
    chk("w1_acc_psel", psel, 1);    chk("w1_acc_pen", penable, 1);
    tick();
    chk("w1_done_psel", psel, 0);   chk("w1_no_rsp", rsp_valid, 0);

    // Write then read back-to-back
    prdata_v = 32'h12345678;
    push(1'b1, 32'h24, 32'h55AA55AA);
    push(1'b0, 32'h20, 32'h0);
    chk("wr_acc_pen", penable, 1);
    tick();
    chk("rd_setup_psel", psel, 1);  chk("rd_setup_pen", penable, 0);
    chk("rd_paddr", paddr, 32'h20); chk("rd_pwrite", pwrite, 0);
    tick();
    chk("rd_acc_pen", penable, 1);
    tick();
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h12345678);
    chk("rd_rsp_err", rsp_err, 0);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    chk("rd_popped", rsp_valid, 0);

    // Command FIFO back-pressure with a stalled slave
    pready = 1'b0;
    for (int i = 0; i < 5; i++) push(1'b1, 32'h100 + 32'(i * 4), 32'hA000 + 32'(i));
    chk("bp_cmd_ready_low", cmd_ready, 0);
    chk("bp_first_paddr", paddr, 32'h100);
    fork
      push(1'b1, 32'h114, 32'hA005);
      begin repeat (3) tick(); pready = 1'b1; end
    join
    wait_idle();
    chk("bp_last_paddr", paddr, 32'h114);
    chk("bp_last_pwdata", pwdata, 32'hA005);

    // Read with three wait states and a slave error
    pready = 1'b0;
    prdata_v = 32'hBADC0FFE;
    push(1'b0, 32'h40, 32'h0);
    chk("ws_setup_pen", penable, 0);
    tick(); chk("ws_acc1_pen", penable, 1);
    tick(); chk("ws_acc2_pen", penable, 1);
    tick(); chk("ws_acc3_pen", penable, 1); chk("ws_acc3_paddr", paddr, 32'h40);
    tick(); chk("ws_acc4_pen", penable, 1);
    pready = 1'b1; pslverr = 1'b1;
    tick();
    pslverr = 1'b0;
    chk("ws_done_psel", psel, 0);
    chk("ws_rsp_valid", rsp_valid, 1);
    chk("ws_rsp_err", rsp_err, 1);
    chk("ws_rsp_rdata", rsp_rdata, 32'hBADC0FFE);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;

    // Response FIFO full blocks a fifth read
    use_fn = 1'b1;
    for (int i = 0; i < 5; i++) push(1'b0, 32'h200 + 32'(i * 4), 32'h0);
    repeat (10) tick();
    chk("rf_rsp_valid", rsp_valid, 1);
    chk("rf_psel_idle", psel, 0);
    chk("rf_busy", busy, 1);
    chk("rf_head", rsp_rdata, 32'hCAFE0200);
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    chk("rf_after_pop_psel", psel, 0);
    tick();
    chk("rf_issue_psel", psel, 1);
    chk("rf_issue_paddr", paddr, 32'h210);
    rsp_ready = 1'b1;
    wait_idle();
    repeat (3) tick();
    chk("rf_drained", rsp_valid, 0);
    rsp_ready = 1'b0;
    use_fn = 1'b0;

    // Reset in the middle of an ACCESS with commands queued
    pready = 1'b0;
    for (int i = 0; i < 3; i++) push(1'b1, 32'h300 + 32'(i * 4), 32'hB000 + 32'(i));
    for (int n = 0; n < 20 && !penable; n++) tick();
    chk("rst_mid_in_access", penable, 1);
    #2 prst = 1'b0;
    #1;
    chk("arst_psel", psel, 0);   chk("arst_penable", penable, 0);
    chk("arst_busy", busy, 0);   chk("arst_rsp_valid", rsp_valid, 0);
    tick();
    prst = 1'b1;
    pready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_psel", psel, 0);
    end
    chk("post_rst_busy", busy, 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
